btn_set_ctrl: RTL and testbench

- Front-end controller for the digital clock's user buttons. Synchronizes, debounces and edge-detects three raw buttons (MODE, UP, DOWN).
- Sequences the time-setting mode state machine and issues single-cycle increment, decrement and seconds-clear commands to the timekeeping counters.
- Supports long-press auto-repeat and an inactivity timeout that returns the clock to normal display.

---
 rtl/btn_set_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_btn_set_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_set_ctrl
// Brief    : Button synchronizer/debouncer and time-setting mode controller
//            with auto-repeat and inactivity timeout for the digital clock.
// Revision : 1.0
// ============================================================================
module btn_set_ctrl #(
   parameter int DB_CYCLES      = 20000,
   parameter int LONG_CYCLES    = 1000000,
   parameter int REP_CYCLES     = 200000,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [1:0] mode,
   output logic       inc_pulse,
   output logic       dec_pulse,
   output logic       sec_clear,
   output logic       blink_en
);

   localparam int c_db_w     = $clog2(DB_CYCLES) + 1;
   localparam int c_hold_max = (LONG_CYCLES > REP_CYCLES) ? LONG_CYCLES : REP_CYCLES;
   localparam int c_hold_w   = $clog2(c_hold_max) + 1;
   localparam int c_idle_w   = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [c_db_w-1:0]   c_db_last   = c_db_w'(DB_CYCLES - 1);
   localparam logic [c_hold_w-1:0] c_long_last = c_hold_w'(LONG_CYCLES - 1);
   localparam logic [c_hold_w-1:0] c_rep_last  = c_hold_w'(REP_CYCLES - 1);
   localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(TIMEOUT_CYCLES - 1);

   localparam int c_btn_mode = 0;
   localparam int c_btn_up   = 1;
   localparam int c_btn_dn   = 2;

   typedef enum logic [1:0] {
      ST_NORMAL  = 2'd0,
      ST_SET_HR  = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_t;

   logic [2:0] w_raw;
   logic [2:0] w_stable;
   logic [2:0] stable_dly_q;
   logic [2:0] press_q;

   assign w_raw = {btn_down, btn_up, btn_mode};

   // Per-button 2-flop synchronizer followed by a run-length debouncer.
   for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      logic              sync1_q;
      logic              sync2_q;
      logic              stable_q;
      logic [c_db_w-1:0] db_cnt_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
         end else begin
            sync1_q <= w_raw[gi];
            sync2_q <= sync1_q;
            if (sync2_q == stable_q) begin
               db_cnt_q <= '0;
            end else if (db_cnt_q == c_db_last) begin
               stable_q <= ~stable_q;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + 1'b1;
            end
         end
      end

      assign w_stable[gi] = stable_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_dly_q <= '0;
         press_q      <= '0;
      end else begin
         stable_dly_q <= w_stable;
         press_q      <= w_stable & ~stable_dly_q;
      end
   end

   state_t              state_q;
   logic                inc_q;
   logic                dec_q;
   logic                sclr_q;
   logic                blink_q;
   logic                rep_on_q;
   logic                rep_dn_q;
   logic                rep_periodic_q;
   logic [c_hold_w-1:0] hold_cnt_q;
   logic [c_idle_w-1:0] idle_cnt_q;

   logic   w_md_press;
   logic   w_up_press;
   logic   w_dn_press;
   logic   w_st_up;
   logic   w_st_dn;
   logic   w_acc_up;
   logic   w_acc_dn;
   logic   w_hold_ok;
   logic   w_hold_end;
   logic   w_rep_fire;
   logic   w_idle_end;
   state_t w_mode_next;

   assign w_md_press  = press_q[c_btn_mode];
   assign w_up_press  = press_q[c_btn_up];
   assign w_dn_press  = press_q[c_btn_dn];
   assign w_st_up     = w_stable[c_btn_up];
   assign w_st_dn     = w_stable[c_btn_dn];
   // A press is rejected whenever the opposite button is debounced-high,
   // which also covers both pressing in the same cycle.
   assign w_acc_up    = w_up_press & ~w_st_dn;
   assign w_acc_dn    = w_dn_press & ~w_st_up;
   assign w_hold_ok   = rep_dn_q ? (w_st_dn & ~w_st_up) : (w_st_up & ~w_st_dn);
   assign w_hold_end  = rep_periodic_q ? (hold_cnt_q == c_rep_last)
                                       : (hold_cnt_q == c_long_last);
   assign w_rep_fire  = rep_on_q & w_hold_ok & w_hold_end;
   assign w_idle_end  = (idle_cnt_q == c_idle_last);
   assign w_mode_next = state_t'(state_q + 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_NORMAL;
         inc_q          <= 1'b0;
         dec_q          <= 1'b0;
         sclr_q         <= 1'b0;
         blink_q        <= 1'b0;
         rep_on_q       <= 1'b0;
         rep_dn_q       <= 1'b0;
         rep_periodic_q <= 1'b0;
         hold_cnt_q     <= '0;
         idle_cnt_q     <= '0;
      end else begin
         inc_q  <= 1'b0;
         dec_q  <= 1'b0;
         sclr_q <= 1'b0;
         if (w_md_press) begin
            state_q    <= w_mode_next;
            blink_q    <= (w_mode_next != ST_NORMAL);
            rep_on_q   <= 1'b0;
            hold_cnt_q <= '0;
            idle_cnt_q <= '0;
         end else begin
            case (state_q)
               ST_NORMAL: begin
                  rep_on_q   <= 1'b0;
                  hold_cnt_q <= '0;
                  idle_cnt_q <= '0;
               end
               ST_SET_SEC: begin
                  if (w_up_press | w_dn_press) begin
                     sclr_q     <= 1'b1;
                     idle_cnt_q <= '0;
                  end else if (w_idle_end) begin
                     state_q    <= ST_NORMAL;
                     blink_q    <= 1'b0;
                     idle_cnt_q <= '0;
                  end else begin
                     idle_cnt_q <= idle_cnt_q + 1'b1;
                  end
               end
               default: begin
                  if (w_acc_up | w_acc_dn) begin
                     inc_q          <= w_acc_up;
                     dec_q          <= w_acc_dn;
                     rep_on_q       <= 1'b1;
                     rep_dn_q       <= w_acc_dn;
                     rep_periodic_q <= 1'b0;
                     hold_cnt_q     <= '0;
                     idle_cnt_q     <= '0;
                  end else begin
                     if (rep_on_q) begin
                        if (!w_hold_ok) begin
                           rep_on_q   <= 1'b0;
                           hold_cnt_q <= '0;
                        end else if (w_hold_end) begin
                           inc_q          <= ~rep_dn_q;
                           dec_q          <= rep_dn_q;
                           rep_periodic_q <= 1'b1;
                           hold_cnt_q     <= '0;
                        end else begin
                           hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                     end
                     // Timeout overrides any repeat state set above.
                     if (w_up_press | w_dn_press | w_rep_fire) begin
                        idle_cnt_q <= '0;
                     end else if (w_idle_end) begin
                        state_q    <= ST_NORMAL;
                        blink_q    <= 1'b0;
                        rep_on_q   <= 1'b0;
                        hold_cnt_q <= '0;
                        idle_cnt_q <= '0;
                     end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end

   assign mode      = state_q;
   assign inc_pulse = inc_q;
   assign dec_pulse = dec_q;
   assign sec_clear = sclr_q;
   assign blink_en  = blink_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_set_ctrl
// Brief    : Self-checking bench for btn_set_ctrl with a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_btn_set_ctrl;

   localparam int DB   = 4;
   localparam int LONG = 20;
   localparam int REP  = 5;
   localparam int TMO  = 100;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       b_mode = 1'b0;
   logic       b_up   = 1'b0;
   logic       b_dn   = 1'b0;
   logic [1:0] mode;
   logic       inc_pulse;
   logic       dec_pulse;
   logic       sec_clear;
   logic       blink_en;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;
   int n_inc = 0, n_dec = 0, n_clr = 0;

   always #5 clk = ~clk;

   btn_set_ctrl #(
      .DB_CYCLES     (DB),
      .LONG_CYCLES   (LONG),
      .REP_CYCLES    (REP),
      .TIMEOUT_CYCLES(TMO)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_mode (b_mode),
      .btn_up   (b_up),
      .btn_down (b_dn),
      .mode     (mode),
      .inc_pulse(inc_pulse),
      .dec_pulse(dec_pulse),
      .sec_clear(sec_clear),
      .blink_en (blink_en)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: event timestamps instead of counters.
   int cyc = 0;
   bit s1[3], s2[3], st[3], stp[3], pr[3];
   int run[3];
   int m;
   bit e_inc, e_dec, e_clr, rep_on, rep_dn;
   int t0, last_act;

   task automatic mreset();
      for (int b = 0; b < 3; b++) begin
         s1[b] = 0; s2[b] = 0; st[b] = 0; stp[b] = 0; pr[b] = 0; run[b] = 0;
      end
      m = 0; e_inc = 0; e_dec = 0; e_clr = 0; rep_on = 0; rep_dn = 0;
      t0 = 0; last_act = cyc;
   endtask

   task automatic mstep();
      bit raw[3];
      bit npr[3];
      bit fire, held;
      raw = '{b_mode, b_up, b_dn};
      cyc++;
      e_inc = 0; e_dec = 0; e_clr = 0;
      if (pr[0]) begin
         m = (m + 1) % 4; rep_on = 0; last_act = cyc;
      end else if (m == 0) begin
         rep_on = 0; last_act = cyc;
      end else if (m == 3) begin
         if (pr[1] || pr[2]) begin e_clr = 1; last_act = cyc; end
         else if (cyc - last_act >= TMO) m = 0;
      end else begin
         if (pr[1] && !st[2]) begin
            e_inc = 1; rep_on = 1; rep_dn = 0; t0 = cyc; last_act = cyc;
         end else if (pr[2] && !st[1]) begin
            e_dec = 1; rep_on = 1; rep_dn = 1; t0 = cyc; last_act = cyc;
         end else begin
            fire = 0;
            if (rep_on) begin
               held = rep_dn ? (st[2] && !st[1]) : (st[1] && !st[2]);
               if (!held) rep_on = 0;
               else if (cyc - t0 >= LONG && (cyc - t0 - LONG) % REP == 0) begin
                  fire = 1;
                  if (rep_dn) e_dec = 1; else e_inc = 1;
               end
            end
            if (pr[1] || pr[2] || fire) last_act = cyc;
            else if (cyc - last_act >= TMO) begin m = 0; rep_on = 0; end
         end
      end
      for (int b = 0; b < 3; b++) begin
         npr[b] = st[b] && !stp[b];
         stp[b] = st[b];
         if (s2[b] != st[b]) begin
            run[b]++;
            if (run[b] == DB) begin st[b] = !st[b]; run[b] = 0; end
         end else begin
            run[b] = 0;
         end
         s2[b] = s1[b];
         s1[b] = raw[b];
         pr[b] = npr[b];
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) mreset();
      else mstep();
   end

   always @(negedge rst_n) mreset();

   always @(negedge clk) begin
      n_inc += int'(inc_pulse);
      n_dec += int'(dec_pulse);
      n_clr += int'(sec_clear);
      if (cmp_en)
         chk("outputs", {26'd0, mode, inc_pulse, dec_pulse, sec_clear, blink_en},
             {26'd0, m[1:0], e_inc, e_dec, e_clr, (m != 0)});
   end

   task automatic set_btn(input int b, input bit v);
      case (b)
         0: b_mode = v;
         1: b_up   = v;
         default: b_dn = v;
      endcase
   endtask

   task automatic hit_mode(input logic [1:0] target, input string tag);
      int n;
      @(negedge clk);
      b_mode = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (mode !== target && n < 40);
      chk({tag, "_latency"}, n - 1, 7);
      b_mode = 1'b0;
      repeat (12) @(negedge clk);
      chk({tag, "_blink"}, blink_en, target != 2'd0);
   endtask

   task automatic until_pulse(input bit dn, output int n);
      n = 0;
      do begin @(posedge clk); #1; n++; end
      while (!(dn ? dec_pulse : inc_pulse) && n < 40);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected below 500000", $time);
      $fatal(1);
   end

   initial begin
      int n, b0, b1, b2, cnt, first_gap, last_off;
      int tm[3];
      bit lv;
      mreset();
      repeat (3) @(negedge clk);
      chk("reset_state", {mode, inc_pulse, dec_pulse, sec_clear, blink_en}, 6'd0);
      @(posedge clk); #2 rst_n = 1'b1;
      cmp_en = 1'b1;
      repeat (5) @(negedge clk);

      // Mode cycling
      hit_mode(2'd1, "mode1");
      hit_mode(2'd2, "mode2");
      hit_mode(2'd3, "mode3");
      hit_mode(2'd0, "mode0");

      // Bounce rejection in SET_HR
      hit_mode(2'd1, "to_hr");
      b0 = n_inc;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         b_up = (i % 4) < 2;
      end
      @(negedge clk);
      b_up = 1'b1;
      until_pulse(1'b0, n);
      chk("bounce_latency", n - 1, 7);
      b_up = 1'b0;
      repeat (15) @(negedge clk);
      chk("bounce_inc_count", n_inc - b0, 1);

      // Auto-repeat in SET_MIN
      hit_mode(2'd2, "to_min");
      @(negedge clk);
      b_dn = 1'b1;
      until_pulse(1'b1, n);
      chk("repeat_press_latency", n - 1, 7);
      cnt = 1; first_gap = -1; last_off = 0;
      for (int off = 1; off <= 100; off++) begin
         @(posedge clk); #1;
         if (dec_pulse) begin
            cnt++;
            if (first_gap < 0) first_gap = off;
            last_off = off;
         end
         if (off == 56) b_dn = 1'b0;
      end
      chk("repeat_count", cnt - 1, 9);
      chk("repeat_first_gap", first_gap, 20);
      chk("repeat_last_offset", last_off, 60);

      // SET_SEC clears seconds only
      hit_mode(2'd3, "to_sec");
      b0 = n_clr; b1 = n_inc;
      @(negedge clk); b_up = 1'b1;
      repeat (10) @(negedge clk); b_up = 1'b0;
      repeat (15) @(negedge clk);
      chk("sec_clear_count", n_clr - b0, 1);
      chk("sec_inc_count", n_inc - b1, 0);

      // Simultaneous UP/DOWN in SET_HR
      hit_mode(2'd0, "to_norm");
      hit_mode(2'd1, "to_hr2");
      b0 = n_inc; b1 = n_dec;
      @(negedge clk); b_up = 1'b1; b_dn = 1'b1;
      repeat (40) @(negedge clk); b_up = 1'b0; b_dn = 1'b0;
      repeat (15) @(negedge clk);
      chk("conflict_inc", n_inc - b0, 0);
      chk("conflict_dec", n_dec - b1, 0);

      // MODE wins over UP, then inactivity timeout
      b0 = n_inc; b1 = n_dec; b2 = n_clr;
      @(negedge clk); b_mode = 1'b1; b_up = 1'b1;
      n = 0;
      do begin @(posedge clk); #1; n++; end while (mode !== 2'd2 && n < 40);
      chk("priority_mode", mode, 2'd2);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (n == 2) begin b_mode = 1'b0; b_up = 1'b0; end
      end while (mode !== 2'd0 && n < 200);
      chk("timeout_cycles", n, 100);
      chk("priority_pulses", (n_inc - b0) + (n_dec - b1) + (n_clr - b2), 0);

      // Reset during UP auto-repeat
      hit_mode(2'd1, "to_hr3");
      @(negedge clk); b_up = 1'b1;
      until_pulse(1'b0, n);
      repeat (22) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("reset_mid_outputs", {mode, inc_pulse, dec_pulse, sec_clear, blink_en}, 6'd0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      b0 = n_inc; b1 = n_dec; b2 = n_clr;
      repeat (40) @(negedge clk);
      chk("post_reset_pulses", (n_inc - b0) + (n_dec - b1) + (n_clr - b2), 0);
      chk("post_reset_mode", mode, 2'd0);
      b_up = 1'b0;
      repeat (10) @(negedge clk);

      // Randomized phase against the model
      for (int b = 0; b < 3; b++) tm[b] = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int b = 0; b < 3; b++) begin
            if (tm[b] == 0) begin
               if (b == 0) begin
                  lv = ($urandom_range(0, 3) == 0);
                  tm[b] = lv ? int'($urandom_range(1, 12)) : int'($urandom_range(5, 60));
               end else begin
                  lv = $urandom_range(0, 1) == 1;
                  tm[b] = int'($urandom_range(1, 45));
               end
               set_btn(b, lv);
            end else begin
               tm[b]--;
            end
         end
         if (i == 1500) begin
            @(posedge clk); #2 rst_n = 1'b0;
            @(posedge clk); #2 rst_n = 1'b1;
         end
      end
      b_mode = 1'b0; b_up = 1'b0; b_dn = 1'b0;
      repeat (20) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
